coin_burst_sequencer: RTL

Front-end stage that feeds the vending-machine controller's 2-bit coin input. It synchronizes and debounces two raw coin sensors and queues accepted coins as codes in a small FIFO. On a vend request it replays the queued codes to the controller on consecutive cycles, then drives one idle cycle (00) to close the transaction. Codes: 01 = 5-unit coin, 10 = 10-unit coin, 00 = no coin.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_debounce.sv | 55 +++++
 rtl/coin_burst_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared coin codes, burst FSM states and coin valuation
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CLOSE = 2'd2
    } burst_state_e;

    // Value of a queued code in 5-unit multiples.
    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-flop synchronizer plus debouncer emitting one pulse per accepted coin
module coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic event_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          armed_q, armed_d;
    logic          event_q, event_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Armed: counting high samples toward an event. Disarmed: counting low samples toward re-arm.
    always_comb begin
        armed_d = armed_q;
        event_d = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == armed_q) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                armed_d = !armed_q;
                event_d = armed_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            armed_q <= 1'b1;
            event_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            armed_q <= armed_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/coin_burst_sequencer.sv
// rtl/coin_burst_sequencer.sv - debounced coin queue replayed as a burst; COIN_AUTO_VEND_EN adds auto-vend on value threshold
module coin_burst_sequencer
    import coin_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 4,
    parameter int PRICE      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin5_raw,
    input  logic                       coin10_raw,
    input  logic                       vend_req,
    output logic [1:0]                 data_out,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       coin_reject
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (DEB_CYCLES < 1 || PRICE < 0) begin : g_bad_params
        $error("DEB_CYCLES must be at least 1 and PRICE non-negative");
    end

    logic ev5, ev10;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin5_raw),
        .event_o(ev5)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (coin10_raw),
        .event_o(ev10)
    );

    logic          hold_v_q, hold_v_d;
    logic [1:0]    hold_code_q, hold_code_d;
    logic          push_v, push_ok, pop, full, start;
    logic [1:0]    push_code;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [1:0]    data_q, data_d;
    burst_state_e  state_q, state_d;

    // Held code always goes first; a debouncer cannot fire two cycles running, so one hold slot suffices.
    always_comb begin
        push_v      = 1'b0;
        push_code   = COIN_NONE;
        hold_v_d    = hold_v_q;
        hold_code_d = hold_code_q;
        if (hold_v_q) begin
            push_v      = 1'b1;
            push_code   = hold_code_q;
            hold_v_d    = ev5 || ev10;
            hold_code_d = ev5 ? COIN_5 : COIN_10;
        end else if (ev5) begin
            push_v      = 1'b1;
            push_code   = COIN_5;
            hold_v_d    = ev10;
            hold_code_d = COIN_10;
        end else if (ev10) begin
            push_v    = 1'b1;
            push_code = COIN_10;
        end
    end

    assign full        = (count_q == CW'(DEPTH));
    assign push_ok     = push_v && !full;
    assign coin_reject = push_v && full;

`ifdef COIN_AUTO_VEND_EN
    localparam int VW = $clog2(2 * DEPTH + 1);
    logic [VW-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (push_ok) value_d = value_d + VW'(coin_value(push_code));
        if (pop)     value_d = value_d - VW'(coin_value(mem_q[rptr_q]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign start = vend_req || (int'(value_q) >= PRICE);
`else
    assign start = vend_req;
`endif

    // The first pop happens in the request cycle so the code is registered onto data_out one cycle later.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = COIN_NONE;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rptr_q];
                    rem_d   = count_q - CW'(1);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rem_q != '0) begin
                    pop    = 1'b1;
                    data_d = mem_q[rptr_q];
                    rem_d  = rem_q - CW'(1);
                end else begin
                    state_d = CLOSE;
                end
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            data_q      <= COIN_NONE;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            hold_v_q    <= 1'b0;
            hold_code_q <= COIN_NONE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= COIN_NONE;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            count_q     <= count_d;
            hold_v_q    <= hold_v_d;
            hold_code_q <= hold_code_d;
            if (push_ok) begin
                mem_q[wptr_q] <= push_code;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
        end
    end

    assign data_out   = data_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;

endmodule
